// File: rtl/encoder_quad.sv
// Quadrature encoder front end: synchronise and debounce A/B, decode full detents into
// signed steps, buffer them in a saturating accumulator and replay them as spaced pulses.
module encoder_quad #(
    parameter int DEBOUNCE = 1000,
    parameter int GAP      = 4,
    parameter int PEND_W   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_a,
    input  logic                     i_b,
    output logic                     o_plus,
    output logic                     o_minus,
    output logic signed [PEND_W-1:0] o_pend,
    output logic                     o_err
);
    localparam int CNT_W  = $clog2(DEBOUNCE);
    localparam int WAIT_W = $clog2(GAP);
    localparam logic signed [PEND_W-1:0] ONE   = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic signed [PEND_W-1:0] P_MAX = {1'b0, {(PEND_W-1){1'b1}}};
    localparam logic signed [PEND_W-1:0] P_MIN = -P_MAX;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PULSE_P = 3'd2,
        ST_PULSE_M = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

    logic [1:0]               sync_p0;
    logic [1:0]               sync_p1;
    logic [1:0]               deb;
    logic [CNT_W-1:0]         stable_cnt;
    logic signed [2:0]        q;
    logic signed [1:0]        step;
    logic signed [PEND_W-1:0] p;
    state_t                   state;
    state_t                   state_nx;
    logic [WAIT_W-1:0]        wait_cnt;

    logic                     load;
    logic                     illegal;
    logic signed [1:0]        dlt;
    logic [3:0]               qsum;
    logic signed [PEND_W-1:0] base;
    logic [PEND_W:0]          sat_res;

    // Successor of a phase pair in clockwise order 00->01->11->10->00.
    function automatic logic [1:0] cw_next(input logic [1:0] x);
        case (x)
            2'b00:   cw_next = 2'b01;
            2'b01:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b10;
            default: cw_next = 2'b00;
        endcase
    endfunction

    function automatic logic signed [1:0] quad_dir(input logic [1:0] from, input logic [1:0] to);
        if (to == cw_next(from))      quad_dir = 2'sb01;
        else if (from == cw_next(to)) quad_dir = 2'sb11;
        else                          quad_dir = 2'sb00;
    endfunction

    // Returns {overflow, result}; a step that would cross the limit is dropped.
    function automatic logic [PEND_W:0] sat_step(input logic signed [PEND_W-1:0] base_v,
                                                 input logic signed [1:0]        st);
        sat_step = {1'b0, base_v};
        if (st == 2'sb01) begin
            if (base_v == P_MAX) sat_step = {1'b1, base_v};
            else                 sat_step = {1'b0, base_v + ONE};
        end else if (st == 2'sb11) begin
            if (base_v == P_MIN) sat_step = {1'b1, base_v};
            else                 sat_step = {1'b0, base_v - ONE};
        end
    endfunction

    always_comb begin
        load    = (sync_p1 != deb) && (stable_cnt == CNT_W'(DEBOUNCE - 1));
        dlt     = quad_dir(deb, sync_p1);
        illegal = load && (dlt == 2'sb00);
        qsum    = {q[2], q} + {{2{dlt[1]}}, dlt};
        base    = p;
        if (state == ST_PULSE_P)      base = p - ONE;
        else if (state == ST_PULSE_M) base = p + ONE;
        sat_res = sat_step(base, step);
    end

    // Stage boundary: synchroniser, debounce and detent decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_p0    <= 2'b11;
            sync_p1    <= 2'b11;
            deb        <= 2'b11;
            stable_cnt <= '0;
            q          <= '0;
            step       <= '0;
        end else begin
            sync_p0 <= {i_a, i_b};
            sync_p1 <= sync_p0;
            if (sync_p0 != sync_p1)
                stable_cnt <= '0;
            else if (stable_cnt != CNT_W'(DEBOUNCE - 1))
                stable_cnt <= stable_cnt + CNT_W'(1);
            step <= '0;
            if (load) begin
                deb <= sync_p1;
                if (illegal) begin
                    q <= '0;
                end else if (sync_p1 == 2'b11) begin
                    q <= '0;
                    if (qsum == 4'b0100)      step <= 2'sb01;
                    else if (qsum == 4'b1100) step <= 2'sb11;
                end else begin
                    q <= qsum[2:0];
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_START:   state_nx = ST_IDLE;
            ST_IDLE: begin
                if (p > 0)      state_nx = ST_PULSE_P;
                else if (p < 0) state_nx = ST_PULSE_M;
            end
            ST_PULSE_P: state_nx = ST_WAIT;
            ST_PULSE_M: state_nx = ST_WAIT;
            ST_WAIT:    if (wait_cnt == WAIT_W'(GAP - 3)) state_nx = ST_IDLE;
            default:    state_nx = ST_START;
        endcase
    end

    // Stage boundary: pending accumulator and pulse scheduler.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_START;
            wait_cnt <= '0;
            p        <= '0;
            o_plus   <= 1'b0;
            o_minus  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
            p        <= sat_res[PEND_W-1:0];
            o_plus   <= (state_nx == ST_PULSE_P);
            o_minus  <= (state_nx == ST_PULSE_M);
            o_err    <= illegal || sat_res[PEND_W];
        end
    end

    assign o_pend = p;
endmodule

// File: tb/tb_encoder_quad.sv
// Bench for encoder_quad: scoreboarded random detent/bounce/illegal traffic on a GAP=4
// instance, plus saturation and mid-burst reset on a GAP=200 instance.
module tb_encoder_quad;
    localparam int DEB  = 4;
    localparam int GAP1 = 4;
    localparam int GAP2 = 200;
    localparam int PW   = 4;
    localparam int PMAX = 2 ** (PW - 1) - 1;

    logic clk = 1'b0;
    logic rst1, rst2, a1, b1, a2, b2;
    logic plus1, minus1, err1, plus2, minus2, err2;
    logic signed [PW-1:0] pend1, pend2;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int drv_cyc = 0;

    typedef struct {
        int sgn;
        int at;
    } exp_t;
    exp_t pq[$];
    int   eq[$];

    int max_pend2 = 0, pulses2 = 0, after_sat2 = 0, errs2 = 0;
    bit sat_seen2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder_quad #(.DEBOUNCE(DEB), .GAP(GAP1), .PEND_W(PW)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_a(a1), .i_b(b1),
        .o_plus(plus1), .o_minus(minus1), .o_pend(pend1), .o_err(err1)
    );

    encoder_quad #(.DEBOUNCE(DEB), .GAP(GAP2), .PEND_W(PW)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_a(a2), .i_b(b2),
        .o_plus(plus2), .o_minus(minus2), .o_pend(pend2), .o_err(err2)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put1(input logic [1:0] v);
        {a1, b1} = v;
        drv_cyc  = cyc;
    endtask

    task automatic put2(input logic [1:0] v);
        {a2, b2} = v;
    endtask

    // A pin change at a negedge is captured by the next posedge (cycle 0); the pulse
    // appears DEBOUNCE+3 edges later, the illegal-transition error DEBOUNCE+1 edges later.
    task automatic detent1(input bit cw, input int h);
        logic [1:0] seq[4];
        if (cw) begin seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; end
        else    begin seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; end
        seq[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            put1(seq[k]);
            if (k == 3) pq.push_back('{cw ? 1 : -1, drv_cyc + DEB + 4});
            hold(h);
        end
    endtask

    task automatic reverse1(input bit cw, input int h);
        logic [1:0] seq[4];
        if (cw) begin seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b10; end
        else    begin seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b01; end
        seq[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            put1(seq[k]);
            hold(h);
        end
    endtask

    task automatic glitch1(input bit on_a, input int k);
        put1(on_a ? 2'b01 : 2'b10);
        hold(k);
        put1(2'b11);
        hold(10);
    endtask

    task automatic illegal1(input bit via01, input int h);
        put1(2'b00);
        eq.push_back(drv_cyc + DEB + 2);
        hold(h);
        put1(via01 ? 2'b01 : 2'b10);
        hold(h);
        put1(2'b11);
        hold(h);
    endtask

    task automatic detent2(input int h);
        logic [1:0] seq[4];
        seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            put2(seq[k]);
            hold(h);
        end
    endtask

    task automatic monitor1();
        int   last_p = -1000;
        bit   prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst1) begin
                prev = 0;
            end else begin
                if (plus1 && minus1) chk(0, "both_pulses", 1, 0);
                if (plus1 || minus1) begin
                    chk(!prev, "pulse_width", 2, 1);
                    chk(cyc - last_p >= GAP1, "pulse_spacing", cyc - last_p, GAP1);
                    last_p = cyc;
                    if (pq.size() == 0) begin
                        chk(0, "unexpected_pulse", plus1 ? 1 : -1, 0);
                    end else begin
                        e = pq.pop_front();
                        chk((plus1 ? 1 : -1) == e.sgn, "pulse_sign", plus1 ? 1 : -1, e.sgn);
                        chk(cyc == e.at, "pulse_latency", cyc, e.at);
                        chk(int'(pend1) == e.sgn, "pend_during_pulse", int'(pend1), e.sgn);
                    end
                end else if (prev) begin
                    chk(pend1 == 0, "pend_after_pulse", int'(pend1), 0);
                end
                prev = plus1 || minus1;
                if (err1) begin
                    if (eq.size() == 0) begin
                        chk(0, "unexpected_err", cyc, 0);
                    end else begin
                        chk(cyc == eq[0], "err_time", cyc, eq[0]);
                        void'(eq.pop_front());
                    end
                end
                if (pq.size() > 0 && cyc > pq[0].at) begin
                    chk(0, "missing_pulse", cyc, pq[0].at);
                    void'(pq.pop_front());
                end
                if (eq.size() > 0 && cyc > eq[0]) begin
                    chk(0, "missing_err", cyc, eq[0]);
                    void'(eq.pop_front());
                end
            end
        end
    endtask

    task automatic monitor2();
        int last = 0;
        bit have = 0, prev = 0, backlog = 0;
        forever begin
            @(negedge clk);
            if (rst2) begin
                have = 0; prev = 0; backlog = 0;
            end else begin
                if (prev) backlog = (pend2 != 0);
                if (minus2) chk(0, "dut2_minus", 1, 0);
                if (plus2) begin
                    chk(!prev, "dut2_pulse_width", 2, 1);
                    if (have) chk(cyc - last >= GAP2, "dut2_min_spacing", cyc - last, GAP2);
                    if (have && backlog) chk(cyc - last == GAP2, "burst_spacing", cyc - last, GAP2);
                    have = 1;
                    last = cyc;
                    pulses2++;
                    if (sat_seen2) after_sat2++;
                end
                if (err2) errs2++;
                if (int'(pend2) > max_pend2) max_pend2 = int'(pend2);
                if (int'(pend2) == PMAX) sat_seen2 = 1;
                prev = plus2;
            end
        end
    endtask

    initial begin
        int  kind, h, n;
        bit  got;
        rst1 = 1'b1; rst2 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a2 = 1'b1; b2 = 1'b1;
        fork
            monitor1();
            monitor2();
        join_none

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(!plus1 && !minus1 && !err1 && pend1 == 0, "reset_state",
                int'({plus1, minus1, err1}) * 100 + int'(pend1), 0);
        end
        rst1 = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            hold(1);
            chk(!plus1 && !minus1 && !err1 && pend1 == 0, "quiet_after_reset",
                int'({plus1, minus1, err1}) * 100 + int'(pend1), 0);
        end

        detent1(1'b1, 10);
        detent1(1'b0, 10);
        glitch1(1'b1, 3);
        reverse1(1'b1, 10);
        illegal1(1'b1, 10);
        detent1(1'b1, 8);

        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 5);
            h    = $urandom_range(6, 10);
            case (kind)
                0, 1, 2: detent1(kind != 1, h);
                3:       glitch1($urandom_range(0, 1) == 1, $urandom_range(1, DEB - 1));
                4:       reverse1($urandom_range(0, 1) == 1, h);
                default: illegal1($urandom_range(0, 1) == 1, h);
            endcase
        end
        hold(40);
        chk(pq.size() == 0, "pulse_queue_empty", pq.size(), 0);
        chk(eq.size() == 0, "err_queue_empty", eq.size(), 0);

        // Fast burst into the slow-draining instance: saturates, then drains.
        max_pend2 = 0; pulses2 = 0; after_sat2 = 0; errs2 = 0; sat_seen2 = 0;
        for (int d = 0; d < 10; d++) detent2(5);
        for (int i = 0; i < 3000 && !(pulses2 == 8 && pend2 == 0); i++) hold(1);
        chk(max_pend2 == PMAX, "sat_peak", max_pend2, PMAX);
        chk(errs2 == 2, "sat_err_count", errs2, 2);
        chk(after_sat2 == PMAX, "drain_pulses", after_sat2, PMAX);
        chk(pulses2 == 8, "burst_total_pulses", pulses2, 8);
        chk(pend2 == 0, "drained_pend", int'(pend2), 0);
        hold(GAP2 + 100);
        chk(pulses2 == 8, "no_extra_pulses", pulses2, 8);

        // Second burst, reset while pulses are still pending.
        sat_seen2 = 0;
        for (int d = 0; d < 10; d++) detent2(5);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pend2 == 3) begin
                got = 1;
                break;
            end
            hold(1);
        end
        chk(got, "reach_pend_3", int'(pend2), 3);
        rst2 = 1'b1;
        hold(1);
        chk(pend2 == 0 && !plus2 && !minus2 && !err2, "mid_reset_outputs",
            int'({plus2, minus2, err2}) * 100 + int'(pend2), 0);
        hold(1);
        rst2 = 1'b0;
        n = pulses2;
        hold(2 * GAP2 + 100);
        chk(pulses2 == n, "no_pulses_after_reset", pulses2, n);
        chk(pend2 == 0, "pend_after_reset", int'(pend2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
